// File: rtl/buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_pkg
//  Description : Shared types and helpers for the ping-pong operand-B buffer.
//                bank_state_e : lifecycle of one bank (FREE/LOADING/READY)
//                bank_idx_w   : width of a bank index for a given bank count
//  Revision    : 1.0 - initial release
// ============================================================================
package buffer_pkg;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_LOADING = 2'd1,
        BANK_READY   = 2'd2
    } bank_state_e;

    // Bank index width; never narrower than one bit so pointers stay legal.
    function automatic int bank_idx_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage : buffer_pkg
`default_nettype wire

// File: rtl/buffer_b_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_b_bank_ctrl
//  Description : Bank bookkeeping for the ping-pong B buffer. Holds one
//                FREE -> LOADING -> READY -> FREE state machine per bank, the
//                load and read bank pointers, and the illegal-op detector.
//  Ports       : clk, rst_n (sync, active low)
//                load_write_addr_valid, load_done   : load-side strobes
//                mm_read_addr_valid, mm_done        : MM-side strobes
//                load_ready / mm_bank_ready         : current bank usable
//                write_accept / read_accept         : strobe qualified by ready
//                load_ptr / rd_ptr                  : current bank indices
//                bank_full                          : bit i = bank i READY
//                err_flags                          : sticky {bad_done, bad_read, bad_write}
//  Config      : BUFFER_B_PP_ERR_EN - when defined, err_flags record illegal
//                ops one cycle after they occur; otherwise err_flags are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_b_bank_ctrl
    import buffer_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = bank_idx_w(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_write_addr_valid,
    input  logic                 load_done,
    input  logic                 mm_read_addr_valid,
    input  logic                 mm_done,
    output logic                 load_ready,
    output logic                 mm_bank_ready,
    output logic                 write_accept,
    output logic                 read_accept,
    output logic [BANK_W-1:0]    load_ptr,
    output logic [BANK_W-1:0]    rd_ptr,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic [2:0]           err_flags
);

    bank_state_e       w_bank_state [NUM_BANKS];
    logic [BANK_W-1:0] r_load_ptr;
    logic [BANK_W-1:0] r_rd_ptr;
    logic              w_load_ready;
    logic              w_mm_ready;
    logic              w_load_done_eff;
    logic              w_mm_done_eff;

    assign w_load_ready    = (w_bank_state[r_load_ptr] == BANK_LOADING);
    assign w_mm_ready      = (w_bank_state[r_rd_ptr]   == BANK_READY);
    // Done pulses only count when their bank is in the matching state, so a
    // stray pulse can never advance a pointer past a bank still in use.
    assign w_load_done_eff = load_done && w_load_ready;
    assign w_mm_done_eff   = mm_done   && w_mm_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_BANKS; i++) begin : g_bank
            localparam logic [BANK_W-1:0] c_idx = BANK_W'(i);

            bank_state_e r_state;
            bank_state_e w_state_nxt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= BANK_FREE;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // The LOADING bank is always the one at load_ptr and the READY
            // bank being drained is the one at rd_ptr, so one bank can never
            // see both done pulses in the same cycle.
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    BANK_FREE: begin
                        if (r_load_ptr == c_idx) begin
                            w_state_nxt = BANK_LOADING;
                        end
                    end
                    BANK_LOADING: begin
                        if (w_load_done_eff && (r_load_ptr == c_idx)) begin
                            w_state_nxt = BANK_READY;
                        end
                    end
                    BANK_READY: begin
                        if (w_mm_done_eff && (r_rd_ptr == c_idx)) begin
                            w_state_nxt = BANK_FREE;
                        end
                    end
                    default: begin
                        w_state_nxt = BANK_FREE;
                    end
                endcase
            end

            assign w_bank_state[i] = r_state;
            assign bank_full[i]    = (r_state == BANK_READY);
        end
    endgenerate

    // Power-of-two bank count: natural wrap gives modulo NUM_BANKS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_ptr <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_load_done_eff) begin
                r_load_ptr <= r_load_ptr + 1'b1;
            end
            if (w_mm_done_eff) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign load_ready    = w_load_ready;
    assign mm_bank_ready = w_mm_ready;
    assign write_accept  = load_write_addr_valid && w_load_ready;
    assign read_accept   = mm_read_addr_valid && w_mm_ready;
    assign load_ptr      = r_load_ptr;
    assign rd_ptr        = r_rd_ptr;

`ifdef BUFFER_B_PP_ERR_EN
    logic [2:0] r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 3'b000;
        end else begin
            r_err <= r_err | {mm_done && !w_mm_ready,
                              mm_read_addr_valid && !w_mm_ready,
                              load_write_addr_valid && !w_load_ready};
        end
    end

    assign err_flags = r_err;
`else
    assign err_flags = 3'b000;
`endif

endmodule : buffer_b_bank_ctrl
`default_nettype wire

// File: rtl/buffer_b_pingpong.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_b_pingpong
//  Description : Multi-bank (ping-pong) operand-B buffer. The load unit fills
//                one bank while the MM unit reads another; banks change hands
//                on load_done / mm_done pulses. All banks share one simple
//                dual-port RAM addressed as {bank, word}.
//  Ports       : clk, rst_n (sync, active low)
//                load_ready, load_write_addr_valid, load_write_addr,
//                load_write_data, load_done          : load (writer) side
//                mm_bank_ready, mm_read_addr_valid, mm_read_addr,
//                mm_read_data_valid, mm_read_data, mm_done : MM (reader) side
//                bank_full  : bit i = bank i READY
//                err_flags  : sticky {bad_done, bad_read, bad_write}
//  Timing      : write = input register + RAM write (2 cycles).
//                read  = input register + RAM (RAM_READ_LATENCY) + output
//                register, i.e. RAM_READ_LATENCY+2 cycles, one read per cycle.
//  Config      : BUFFER_B_PP_ERR_EN - enables the err_flags recorder.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_b_pingpong
    import buffer_pkg::*;
#(
    parameter int    BUFFER_ADDR_WIDTH  = 9,
    parameter int    BUFFER_DATA_WIDTH  = 512,
    parameter int    NUM_BANKS          = 2,
    parameter int    RAM_READ_LATENCY   = 2,
    parameter string MEM_POOL_PRIMITIVE = "auto"
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         load_ready,
    input  logic                         load_write_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
    input  logic                         load_done,
    output logic                         mm_bank_ready,
    input  logic                         mm_read_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
    output logic                         mm_read_data_valid,
    output logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
    input  logic                         mm_done,
    output logic [NUM_BANKS-1:0]         bank_full,
    output logic [2:0]                   err_flags
);

    localparam int c_bank_w  = bank_idx_w(NUM_BANKS);
    localparam int c_phys_aw = c_bank_w + BUFFER_ADDR_WIDTH;
    localparam int c_depth   = 1 << c_phys_aw;

    logic                         w_write_accept;
    logic                         w_read_accept;
    logic [c_bank_w-1:0]          w_load_ptr;
    logic [c_bank_w-1:0]          w_rd_ptr;

    logic                         r_wr_vld;
    logic [c_phys_aw-1:0]         r_wr_addr;
    logic [BUFFER_DATA_WIDTH-1:0] r_wr_data;

    logic                         r_rd_vld;
    logic [c_phys_aw-1:0]         r_rd_addr;

    // Stage k holds RAM output data/valid k+1 cycles after the RAM read.
    logic [RAM_READ_LATENCY-1:0]  r_vld_pipe;
    logic [BUFFER_DATA_WIDTH-1:0] r_dat_pipe [RAM_READ_LATENCY];

    logic                         r_out_vld;
    logic [BUFFER_DATA_WIDTH-1:0] r_out_data;

    buffer_b_bank_ctrl #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (c_bank_w)
    ) u_bank_ctrl (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .load_write_addr_valid (load_write_addr_valid),
        .load_done             (load_done),
        .mm_read_addr_valid    (mm_read_addr_valid),
        .mm_done               (mm_done),
        .load_ready            (load_ready),
        .mm_bank_ready         (mm_bank_ready),
        .write_accept          (w_write_accept),
        .read_accept           (w_read_accept),
        .load_ptr              (w_load_ptr),
        .rd_ptr                (w_rd_ptr),
        .bank_full             (bank_full),
        .err_flags             (err_flags)
    );

    // ------------------------------------------------------------------
    // Input registers. The bank index is captured with the request, so a
    // write issued together with load_done lands in the bank being closed
    // and a read issued together with mm_done reads the bank being freed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_vld <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_wr_vld <= w_write_accept;
            r_rd_vld <= w_read_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write_accept) begin
            r_wr_addr <= {w_load_ptr, load_write_addr};
            r_wr_data <= load_write_data;
        end
        if (w_read_accept) begin
            r_rd_addr <= {w_rd_ptr, mm_read_addr};
        end
    end

    // ------------------------------------------------------------------
    // Shared RAM, read-first. A freed bank can only be rewritten two cycles
    // after mm_done at the earliest (one cycle to re-enter LOADING, one in
    // the write register), while a read issued on the mm_done cycle has
    // already sampled the array by then, so it sees the old contents.
    // ------------------------------------------------------------------
    generate
        if (MEM_POOL_PRIMITIVE == "ultra") begin : g_ram_ultra
            (* ram_style = "ultra" *) logic [BUFFER_DATA_WIDTH-1:0] r_mem [c_depth];

            always_ff @(posedge clk) begin
                if (r_wr_vld) begin
                    r_mem[r_wr_addr] <= r_wr_data;
                end
                if (r_rd_vld) begin
                    r_dat_pipe[0] <= r_mem[r_rd_addr];
                end
            end
        end else if (MEM_POOL_PRIMITIVE == "block") begin : g_ram_block
            (* ram_style = "block" *) logic [BUFFER_DATA_WIDTH-1:0] r_mem [c_depth];

            always_ff @(posedge clk) begin
                if (r_wr_vld) begin
                    r_mem[r_wr_addr] <= r_wr_data;
                end
                if (r_rd_vld) begin
                    r_dat_pipe[0] <= r_mem[r_rd_addr];
                end
            end
        end else if (MEM_POOL_PRIMITIVE == "distributed") begin : g_ram_dist
            (* ram_style = "distributed" *) logic [BUFFER_DATA_WIDTH-1:0] r_mem [c_depth];

            always_ff @(posedge clk) begin
                if (r_wr_vld) begin
                    r_mem[r_wr_addr] <= r_wr_data;
                end
                if (r_rd_vld) begin
                    r_dat_pipe[0] <= r_mem[r_rd_addr];
                end
            end
        end else begin : g_ram_auto
            logic [BUFFER_DATA_WIDTH-1:0] r_mem [c_depth];

            always_ff @(posedge clk) begin
                if (r_wr_vld) begin
                    r_mem[r_wr_addr] <= r_wr_data;
                end
                if (r_rd_vld) begin
                    r_dat_pipe[0] <= r_mem[r_rd_addr];
                end
            end
        end
    endgenerate

    // RAM output pipeline: stage 0 is the array read register above, the
    // remaining stages model the extra output registers of the primitive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe[0] <= 1'b0;
        end else begin
            r_vld_pipe[0] <= r_rd_vld;
        end
    end

    genvar k;
    generate
        for (k = 1; k < RAM_READ_LATENCY; k++) begin : g_ram_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld_pipe[k] <= 1'b0;
                end else begin
                    r_vld_pipe[k] <= r_vld_pipe[k-1];
                end
            end

            always_ff @(posedge clk) begin
                r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
        end
    endgenerate

    // Output register; data is forced to zero whenever it is not valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_out_vld  <= r_vld_pipe[RAM_READ_LATENCY-1];
            r_out_data <= r_vld_pipe[RAM_READ_LATENCY-1] ?
                          r_dat_pipe[RAM_READ_LATENCY-1] : '0;
        end
    end

    assign mm_read_data_valid = r_out_vld;
    assign mm_read_data       = r_out_data;

endmodule : buffer_b_pingpong
`default_nettype wire

// File: tb/tb_buffer_b_pingpong.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buffer_b_pingpong
//  Description : Directed self-checking bench for buffer_b_pingpong at the
//                default parameters (AW=9, DW=512, 2 banks, RAM latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_b_pingpong;

    localparam int AW = 9;
    localparam int DW = 512;
    localparam int NB = 2;

`ifdef BUFFER_B_PP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_ready;
    logic          load_write_addr_valid;
    logic [AW-1:0] load_write_addr;
    logic [DW-1:0] load_write_data;
    logic          load_done;
    logic          mm_bank_ready;
    logic          mm_read_addr_valid;
    logic [AW-1:0] mm_read_addr;
    logic          mm_read_data_valid;
    logic [DW-1:0] mm_read_data;
    logic          mm_done;
    logic [NB-1:0] bank_full;
    logic [2:0]    err_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    buffer_b_pingpong dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .load_ready            (load_ready),
        .load_write_addr_valid (load_write_addr_valid),
        .load_write_addr       (load_write_addr),
        .load_write_data       (load_write_data),
        .load_done             (load_done),
        .mm_bank_ready         (mm_bank_ready),
        .mm_read_addr_valid    (mm_read_addr_valid),
        .mm_read_addr          (mm_read_addr),
        .mm_read_data_valid    (mm_read_data_valid),
        .mm_read_data          (mm_read_data),
        .mm_done               (mm_done),
        .bank_full             (bank_full),
        .err_flags             (err_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_write_addr_valid = 1'b0;
        load_done             = 1'b0;
        mm_read_addr_valid    = 1'b0;
        mm_done               = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        load_write_addr = '0;
        load_write_data = '0;
        mm_read_addr    = '0;
        idle();
        step();
        step();

        // Reset state
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_mm_bank_ready", 32'(mm_bank_ready), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_rd_valid", 32'(mm_read_data_valid), 32'd0);
        chkd("rst_rd_data", mm_read_data, '0);
        chk("rst_err", 32'(err_flags), 32'd0);

        rst_n = 1'b1;
        step();
        chk("post_rst_load_ready", 32'(load_ready), 32'd1);

        // 1: fill bank0 addr 0..5 with A0..A5, hand over, read 0..3
        for (int a = 0; a < 6; a++) begin
            load_write_addr_valid = 1'b1;
            load_write_addr       = AW'(a);
            load_write_data       = DW'(32'hA0 + a);
            step();
        end
        load_write_addr_valid = 1'b0;
        load_done             = 1'b1;
        step();
        load_done = 1'b0;
        chk("t1_bank_full", 32'(bank_full), 32'd1);
        chk("t1_mm_bank_ready", 32'(mm_bank_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            mm_read_addr_valid = (i < 4);
            mm_read_addr       = AW'(i);
            if (i == 0) chk("t1_load_gap", 32'(load_ready), 32'd0);
            if (i == 1) chk("t1_load_ready_bank1", 32'(load_ready), 32'd1);
            if (i < 4) begin
                chk("t1_early_valid", 32'(mm_read_data_valid), 32'd0);
                chkd("t1_idle_data", mm_read_data, '0);
            end else begin
                chk("t1_valid", 32'(mm_read_data_valid), 32'd1);
                chkd("t1_data", mm_read_data, DW'(32'hA0 + i - 4));
            end
            step();
        end
        mm_read_addr_valid = 1'b0;
        chk("t1_tail_valid", 32'(mm_read_data_valid), 32'd0);

        // 2: fill bank1 while re-reading bank0, then close bank1
        for (int i = 0; i < 9; i++) begin
            load_write_addr_valid = (i < 4);
            load_write_addr       = AW'(i);
            load_write_data       = DW'(32'hB0 + i);
            mm_read_addr_valid    = (i < 4);
            mm_read_addr          = AW'(i);
            load_done             = (i == 4);
            if (i < 4) chk("t2_no_stall", 32'(load_ready), 32'd1);
            if (i == 5) begin
                chk("t2_bank_full", 32'(bank_full), 32'd3);
                chk("t2_load_blocked", 32'(load_ready), 32'd0);
            end
            if (i >= 4 && i < 8) begin
                chk("t2_valid", 32'(mm_read_data_valid), 32'd1);
                chkd("t2_data", mm_read_data, DW'(32'hA0 + i - 4));
            end
            if (i == 8) chk("t2_tail_valid", 32'(mm_read_data_valid), 32'd0);
            step();
        end
        idle();

        // 3: third load attempt while both banks READY is dropped
        load_write_addr_valid = 1'b1;
        load_write_addr       = AW'(0);
        load_write_data       = DW'(32'hEE);
        chk("t3_load_ready", 32'(load_ready), 32'd0);
        step();
        idle();
        chk("t3_err", 32'(err_flags), 32'({2'b00, ERR_EN}));

        // 4: read addr 5 on the mm_done cycle, then overwrite addr 5
        mm_done            = 1'b1;
        mm_read_addr_valid = 1'b1;
        mm_read_addr       = AW'(5);
        step();
        idle();
        chk("t4_bank_full", 32'(bank_full), 32'd2);
        chk("t4_mm_bank_ready", 32'(mm_bank_ready), 32'd1);
        chk("t4_load_still_blocked", 32'(load_ready), 32'd0);
        step();
        chk("t4_load_ready_back", 32'(load_ready), 32'd1);
        load_write_addr_valid = 1'b1;
        load_write_addr       = AW'(5);
        load_write_data       = DW'(32'hFF);
        step();
        idle();
        chk("t4_early_valid", 32'(mm_read_data_valid), 32'd0);
        step();
        chk("t4_valid", 32'(mm_read_data_valid), 32'd1);
        chkd("t4_old_data", mm_read_data, DW'(32'hA5));
        step();
        chk("t4_tail_valid", 32'(mm_read_data_valid), 32'd0);

        // 5: release bank1, then illegal read and illegal mm_done
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
        chk("t5_mm_bank_ready", 32'(mm_bank_ready), 32'd0);
        chk("t5_bank_full", 32'(bank_full), 32'd0);
        mm_read_addr_valid = 1'b1;
        mm_read_addr       = AW'(0);
        step();
        idle();
        chk("t5_err_read", 32'(err_flags), 32'({1'b0, ERR_EN, ERR_EN}));
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
        chk("t5_err_done", 32'(err_flags), 32'({ERR_EN, ERR_EN, ERR_EN}));
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_valid", 32'(mm_read_data_valid), 32'd0);
            step();
        end
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("t5_bank0_ready", 32'(mm_bank_ready), 32'd1);
        chk("t5_bank_full", 32'(bank_full), 32'd1);
        for (int i = 0; i < 6; i++) begin
            mm_read_addr_valid = (i < 2);
            mm_read_addr       = (i == 0) ? AW'(0) : AW'(5);
            if (i == 4) chkd("t5_addr0_kept", mm_read_data, DW'(32'hA0));
            if (i == 5) chkd("t5_addr5_new", mm_read_data, DW'(32'hFF));
            step();
        end
        idle();

        // 6: reset with three reads in flight
        for (int i = 0; i < 3; i++) begin
            mm_read_addr_valid = 1'b1;
            mm_read_addr       = AW'(i);
            chk("t6_pre_valid", 32'(mm_read_data_valid), 32'd0);
            step();
        end
        mm_read_addr_valid = 1'b0;
        rst_n              = 1'b0;
        chk("t6_pre_valid", 32'(mm_read_data_valid), 32'd0);
        step();
        chk("t6_rst_valid", 32'(mm_read_data_valid), 32'd0);
        chkd("t6_rst_data", mm_read_data, '0);
        chk("t6_rst_load_ready", 32'(load_ready), 32'd0);
        chk("t6_rst_mm_ready", 32'(mm_bank_ready), 32'd0);
        chk("t6_rst_bank_full", 32'(bank_full), 32'd0);
        chk("t6_rst_err", 32'(err_flags), 32'd0);
        rst_n = 1'b1;
        step();
        chk("t6_bank0_loading", 32'(load_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_post_valid", 32'(mm_read_data_valid), 32'd0);
            step();
        end
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("t6_mm_bank_ready", 32'(mm_bank_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            mm_read_addr_valid = (i < 2);
            mm_read_addr       = (i == 0) ? AW'(0) : AW'(5);
            if (i == 4) chkd("t6_ram_kept_0", mm_read_data, DW'(32'hA0));
            if (i == 5) chkd("t6_ram_kept_5", mm_read_data, DW'(32'hFF));
            step();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_buffer_b_pingpong
`default_nettype wire
